// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ready bus between the MEM stage and the data memory.
interface mem_stage_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: sequences data-memory accesses, resolves BEQ, loads MEM/WB.
// Optional access abort after TIMEOUT cycles is enabled by defining DMEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [2:0]          mem_ctl,
    input  logic [1:0]          wb_ctl,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                zero,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [REG_W-1:0]    rd,
    input  logic [DATA_W-1:0]   branch_target,
    mem_stage_ctrl_if.master    dmem,
    output logic                stall,
    output logic                pcsrc,
    output logic [DATA_W-1:0]   branch_addr,
    output logic                memwb_valid,
    output logic [1:0]          memwb_wb,
    output logic [DATA_W-1:0]   memwb_rdata,
    output logic [DATA_W-1:0]   memwb_alu,
    output logic [REG_W-1:0]    memwb_rd,
    output logic                err
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e              state_q, state_d;
    logic                req_q, we_q;
    logic [DATA_W-1:0]   addr_q, wdata_q;
    logic [1:0]          acc_wb_q;
    logic [REG_W-1:0]    acc_rd_q;
    logic                memwb_valid_q;
    logic [1:0]          memwb_wb_q;
    logic [DATA_W-1:0]   memwb_rdata_q, memwb_alu_q;
    logic [REG_W-1:0]    memwb_rd_q;
    logic                err_q;

    logic mem_op, illegal, misaligned, start, xfer, timeout;

    always_comb begin
        mem_op     = mem_ctl[0] ^ mem_ctl[1];
        illegal    = mem_ctl[0] & mem_ctl[1];
        misaligned = mem_op & (alu_result[1:0] != 2'b00);
        start      = in_valid & mem_op & ~misaligned;
        xfer       = req_q & dmem.ready;
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != StAccess) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A ready arriving on the final allowed cycle still wins over the abort.
    assign timeout = (state_q == StAccess) & ~dmem.ready & (cnt_q == CntW'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        pcsrc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall = start;
                pcsrc = in_valid & mem_ctl[2] & zero;
                if (start) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                stall = 1'b1;
                if (xfer || timeout) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            acc_wb_q      <= '0;
            acc_rd_q      <= '0;
            memwb_valid_q <= 1'b0;
            memwb_wb_q    <= '0;
            memwb_rdata_q <= '0;
            memwb_alu_q   <= '0;
            memwb_rd_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle) begin
                memwb_valid_q <= in_valid & ~start;
                if (start) begin
                    req_q    <= 1'b1;
                    we_q     <= mem_ctl[1];
                    addr_q   <= alu_result;
                    wdata_q  <= store_data;
                    acc_wb_q <= wb_ctl;
                    acc_rd_q <= rd;
                end else if (in_valid) begin
                    // Branches and rejected accesses must not write the register file.
                    memwb_wb_q    <= (illegal | misaligned | mem_ctl[2]) ? 2'b00 : wb_ctl;
                    memwb_rdata_q <= '0;
                    memwb_alu_q   <= alu_result;
                    memwb_rd_q    <= rd;
                end
                if (in_valid && (illegal || misaligned)) begin
                    err_q <= 1'b1;
                end
            end else begin
                memwb_valid_q <= xfer | timeout;
                if (xfer) begin
                    req_q         <= 1'b0;
                    memwb_wb_q    <= acc_wb_q;
                    memwb_rdata_q <= we_q ? '0 : dmem.rdata;
                    memwb_alu_q   <= addr_q;
                    memwb_rd_q    <= acc_rd_q;
                end else if (timeout) begin
                    req_q         <= 1'b0;
                    err_q         <= 1'b1;
                    memwb_wb_q    <= 2'b00;
                    memwb_rdata_q <= '0;
                    memwb_alu_q   <= addr_q;
                    memwb_rd_q    <= acc_rd_q;
                end
            end
        end
    end

    assign dmem.req    = req_q;
    assign dmem.we     = we_q;
    assign dmem.addr   = addr_q;
    assign dmem.wdata  = wdata_q;
    assign branch_addr = branch_target;
    assign memwb_valid = memwb_valid_q;
    assign memwb_wb    = memwb_wb_q;
    assign memwb_rdata = memwb_rdata_q;
    assign memwb_alu   = memwb_alu_q;
    assign memwb_rd    = memwb_rd_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus a randomized mix
// checked against a transaction-level model of the MEM stage.
module tb_mem_stage_ctrl;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [2:0]        mem_ctl;
    logic [1:0]        wb_ctl;
    logic [31:0]       alu_result;
    logic              zero;
    logic [31:0]       store_data;
    logic [4:0]        rd;
    logic [31:0]       branch_target;
    logic              stall, pcsrc, memwb_valid, err;
    logic [31:0]       branch_addr, memwb_rdata, memwb_alu;
    logic [1:0]        memwb_wb;
    logic [4:0]        memwb_rd;

    int checks = 0;
    int passes = 0;
    bit err_exp = 1'b0;

    always #5 clk = ~clk;

    mem_stage_ctrl_if #(.DATA_W(DATA_W)) dmem ();

    mem_stage_ctrl #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_ctl(mem_ctl), .wb_ctl(wb_ctl),
        .alu_result(alu_result), .zero(zero), .store_data(store_data), .rd(rd),
        .branch_target(branch_target), .dmem(dmem), .stall(stall), .pcsrc(pcsrc),
        .branch_addr(branch_addr), .memwb_valid(memwb_valid), .memwb_wb(memwb_wb),
        .memwb_rdata(memwb_rdata), .memwb_alu(memwb_alu), .memwb_rd(memwb_rd), .err(err)
    );

    task automatic idle_inputs();
        in_valid = 0; mem_ctl = 0; wb_ctl = 0; alu_result = 0; zero = 0;
        store_data = 0; rd = 0; branch_target = 0; dmem.ready = 0; dmem.rdata = 0;
    endtask

    // One non-stalling entry; returns same-cycle outputs and dmem.req of the next cycle.
    task automatic drive_simple(input logic [2:0] mc, input logic [1:0] wb,
                                input logic [31:0] alu, input logic z, input logic [4:0] rdi,
                                input logic [31:0] tgt, output logic o_stall,
                                output logic o_pcsrc, output logic [31:0] o_baddr,
                                output logic o_req);
        @(negedge clk);
        in_valid = 1; mem_ctl = mc; wb_ctl = wb; alu_result = alu; zero = z; rd = rdi;
        branch_target = tgt; store_data = $urandom;
        #1;
        o_stall = stall; o_pcsrc = pcsrc; o_baddr = branch_addr;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        o_req = dmem.req;
    endtask

    // Memory access; the slave answers ready on the lat-th cycle that req is high.
    // Upstream inputs are scrambled while the access is in flight.
    task automatic run_access(input logic [2:0] mc, input logic [1:0] wb,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [4:0] rdi, input int lat, input logic [31:0] rdata,
                              output int stall_cnt, output int req_cnt,
                              output bit bus_ok, output bit side_ok);
        stall_cnt = 0; req_cnt = 0; bus_ok = 1; side_ok = 1;
        @(negedge clk);
        in_valid = 1; mem_ctl = mc; wb_ctl = wb; alu_result = addr; store_data = data;
        rd = rdi; zero = 1'($urandom); branch_target = $urandom; dmem.ready = 0;
        #1;
        if (stall === 1'b1) stall_cnt++;
        if (dmem.req !== 1'b0) side_ok = 0;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom); mem_ctl = 3'($urandom); wb_ctl = 2'($urandom);
            alu_result = $urandom; zero = 1'($urandom); store_data = $urandom;
            rd = 5'($urandom);
            dmem.ready = (k == lat);
            dmem.rdata = (k == lat) ? rdata : $urandom;
            #1;
            if (stall === 1'b1) stall_cnt++;
            if (pcsrc !== 1'b0 || memwb_valid !== 1'b0) side_ok = 0;
            if (dmem.req === 1'b1) begin
                req_cnt++;
                if (dmem.we !== mc[1] || dmem.addr !== addr || (mc[1] && dmem.wdata !== data))
                    bus_ok = 0;
            end
            @(posedge clk);
            if (k == lat) break;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        if (stall === 1'b1) stall_cnt++;
        if (dmem.req !== 1'b0) side_ok = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if ({dmem.req, dmem.we, dmem.addr, dmem.wdata, memwb_valid, memwb_wb, memwb_rdata,
             memwb_alu, memwb_rd, err} !== '0)
            $display("FAIL reset_regs: got req=%b we=%b addr=%h v=%b wb=%b err=%b, required 0",
                     dmem.req, dmem.we, dmem.addr, memwb_valid, memwb_wb, err);
        else passes++;
        checks++;
        if ({stall, pcsrc} !== 2'b00)
            $display("FAIL reset_comb: got stall=%b pcsrc=%b, required 0 0", stall, pcsrc);
        else passes++;
    endtask

    task automatic test_rtype();
        logic s, p, r;
        logic [31:0] b;
        @(negedge clk);
        dmem.ready = 1;  // stray ready with no request must be ignored
        drive_simple(3'b000, 2'b10, 32'h1234, 1'b1, 5'd7, 32'h0, s, p, b, r);
        checks++;
        if (s !== 1'b0) $display("FAIL rtype_stall: got %b required 0", s); else passes++;
        checks++;
        if ({memwb_valid, memwb_wb, memwb_alu, memwb_rd} !== {1'b1, 2'b10, 32'h1234, 5'd7})
            $display("FAIL rtype_memwb: got v=%b wb=%b alu=%h rd=%0d required 1 10 1234 7",
                     memwb_valid, memwb_wb, memwb_alu, memwb_rd);
        else passes++;
        checks++;
        if (r !== 1'b0) $display("FAIL rtype_req: got %b required 0", r); else passes++;
        @(negedge clk);
        #1;
        checks++;
        if ({memwb_valid, memwb_alu} !== {1'b0, 32'h1234})
            $display("FAIL bubble_hold: got v=%b alu=%h required 0 1234", memwb_valid, memwb_alu);
        else passes++;
    endtask

    task automatic test_load();
        int sc, rc;
        bit bo, so;
        run_access(3'b001, 2'b01, 32'h40, 32'h0, 5'd3, 3, 32'hDEADBEEF, sc, rc, bo, so);
        checks++;
        if (sc != 4) $display("FAIL lw_stall_cycles: got %0d required 4", sc); else passes++;
        checks++;
        if (rc != 3 || !bo || !so)
            $display("FAIL lw_bus: got req_cycles=%0d bus_ok=%0d side_ok=%0d required 3 1 1",
                     rc, bo, so);
        else passes++;
        checks++;
        if ({memwb_valid, memwb_wb, memwb_rdata, memwb_alu, memwb_rd} !==
            {1'b1, 2'b01, 32'hDEADBEEF, 32'h40, 5'd3})
            $display("FAIL lw_memwb: got v=%b wb=%b rdata=%h alu=%h rd=%0d",
                     memwb_valid, memwb_wb, memwb_rdata, memwb_alu, memwb_rd);
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (memwb_valid !== 1'b0) $display("FAIL lw_pulse: got %b required 0", memwb_valid);
        else passes++;
    endtask

    task automatic test_store();
        int sc, rc;
        bit bo, so;
        run_access(3'b010, 2'b00, 32'h10, 32'hA5A5A5A5, 5'd0, 1, 32'hFFFF0000, sc, rc, bo, so);
        checks++;
        if (sc != 2 || rc != 1)
            $display("FAIL sw_timing: got stall=%0d req=%0d required 2 1", sc, rc);
        else passes++;
        checks++;
        if (!bo || !so) $display("FAIL sw_bus: got bus_ok=%0d side_ok=%0d required 1 1", bo, so);
        else passes++;
        checks++;
        if ({memwb_valid, memwb_wb, memwb_rdata} !== {1'b1, 2'b00, 32'h0})
            $display("FAIL sw_memwb: got v=%b wb=%b rdata=%h required 1 00 0",
                     memwb_valid, memwb_wb, memwb_rdata);
        else passes++;
    endtask

    task automatic test_branch();
        logic s, p, r;
        logic [31:0] b;
        drive_simple(3'b100, 2'b11, 32'h0, 1'b1, 5'd9, 32'h200, s, p, b, r);
        checks++;
        if ({p, b, s} !== {1'b1, 32'h200, 1'b0})
            $display("FAIL beq_taken: got pcsrc=%b addr=%h stall=%b required 1 200 0", p, b, s);
        else passes++;
        checks++;
        if ({memwb_valid, memwb_wb} !== 3'b100)
            $display("FAIL beq_memwb: got v=%b wb=%b required 1 00", memwb_valid, memwb_wb);
        else passes++;
        drive_simple(3'b100, 2'b10, 32'h5, 1'b0, 5'd9, 32'h300, s, p, b, r);
        checks++;
        if (p !== 1'b0) $display("FAIL beq_not_taken: got pcsrc=%b required 0", p);
        else passes++;
    endtask

    task automatic test_misaligned();
        logic s, p, r;
        logic [31:0] b;
        drive_simple(3'b001, 2'b01, 32'h41, 1'b0, 5'd4, 32'h0, s, p, b, r);
        err_exp = 1;
        checks++;
        if ({s, r} !== 2'b00) $display("FAIL misalign_noreq: got stall=%b req=%b required 0 0", s, r);
        else passes++;
        checks++;
        if ({err, memwb_valid, memwb_wb} !== 4'b1100)
            $display("FAIL misalign_err: got err=%b v=%b wb=%b required 1 1 00",
                     err, memwb_valid, memwb_wb);
        else passes++;
        drive_simple(3'b011, 2'b11, 32'h80, 1'b0, 5'd4, 32'h0, s, p, b, r);
        drive_simple(3'b000, 2'b10, 32'h7, 1'b0, 5'd1, 32'h0, s, p, b, r);
        checks++;
        if ({err, r} !== 2'b10) $display("FAIL err_sticky: got err=%b req=%b required 1 0", err, r);
        else passes++;
    endtask

    // Randomized mix against a transaction-level model of each entry's MEM/WB result.
    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind, lat, sc, rc;
            bit bo, so;
            logic s, p, r;
            logic [31:0] b, addr, data, resp, tgt, exp_rdata;
            logic [1:0] wb, exp_wb;
            logic [4:0] rdi;
            logic [2:0] mc;
            logic z, exp_pc;
            int exp_stall;
            kind = $urandom_range(0, 4);
            wb = 2'($urandom); rdi = 5'($urandom); data = $urandom; resp = $urandom;
            tgt = $urandom; z = 1'($urandom); lat = $urandom_range(1, 6);
            addr = $urandom & 32'hFFFF_FFFC;
            exp_rdata = 0; exp_pc = 0; exp_wb = wb; exp_stall = 0;
            if (kind == 1 || kind == 2) begin
                mc = (kind == 1) ? 3'b001 : 3'b010;
                exp_rdata = (kind == 1) ? resp : 32'h0;
                exp_stall = lat + 1;
                run_access(mc, wb, addr, data, rdi, lat, resp, sc, rc, bo, so);
                checks++;
                if (sc != exp_stall || rc != lat || !bo || !so)
                    $display("FAIL rand_access[%0d]: got stall=%0d req=%0d ok=%0d%0d required %0d %0d 1 1",
                             n, sc, rc, bo, so, exp_stall, lat);
                else passes++;
            end else begin
                if (kind == 0) mc = 3'b000;
                else if (kind == 3) mc = 3'b100;
                else if ($urandom_range(0, 1) == 0) mc = 3'b011;
                else begin
                    mc = {2'b00, 1'b1} << $urandom_range(0, 1);
                    addr = addr | 32'($urandom_range(1, 3));
                end
                if (kind >= 3) exp_wb = 2'b00;
                if (kind == 3) exp_pc = z;
                if (kind == 4) err_exp = 1;
                drive_simple(mc, wb, addr, z, rdi, tgt, s, p, b, r);
                checks++;
                if ({s, p, b, r} !== {1'b0, exp_pc, tgt, 1'b0})
                    $display("FAIL rand_comb[%0d]: got stall=%b pcsrc=%b baddr=%h req=%b required 0 %b %h 0",
                             n, s, p, b, r, exp_pc, tgt);
                else passes++;
            end
            checks++;
            if ({memwb_valid, memwb_wb, memwb_alu, memwb_rd, err} !==
                {1'b1, exp_wb, addr, rdi, err_exp} ||
                (kind inside {1, 2} && memwb_rdata !== exp_rdata))
                $display("FAIL rand_memwb[%0d]: got v=%b wb=%b alu=%h rd=%0d rdata=%h err=%b required 1 %b %h %0d %h %b",
                         n, memwb_valid, memwb_wb, memwb_alu, memwb_rd, memwb_rdata, err,
                         exp_wb, addr, rdi, exp_rdata, err_exp);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_access();
        int pulses = 0;
        logic s, p, r;
        logic [31:0] b;
        @(negedge clk);
        in_valid = 1; mem_ctl = 3'b001; wb_ctl = 2'b01; alu_result = 32'h80; rd = 5'd2;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        checks++;
        if ({dmem.req, memwb_valid, err} !== 3'b000)
            $display("FAIL rst_mid: got req=%b v=%b err=%b required 0 0 0", dmem.req, memwb_valid, err);
        else passes++;
        err_exp = 0;
        @(negedge clk);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            dmem.ready = 1;
            #1;
            if (memwb_valid === 1'b1 || dmem.req === 1'b1) pulses++;
        end
        dmem.ready = 0;
        checks++;
        if (pulses != 0) $display("FAIL rst_dropped: got %0d active cycles required 0", pulses);
        else passes++;
        drive_simple(3'b000, 2'b10, 32'h99, 1'b0, 5'd5, 32'h0, s, p, b, r);
        checks++;
        if ({s, memwb_valid, memwb_alu} !== {1'b0, 1'b1, 32'h99})
            $display("FAIL rst_idle: got stall=%b v=%b alu=%h required 0 1 99", s, memwb_valid, memwb_alu);
        else passes++;
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int rc = 0, pulses = 0, sc;
        bit bo, so;
        logic [1:0] pulse_wb = 2'b11;
        @(negedge clk);
        in_valid = 1; mem_ctl = 3'b001; wb_ctl = 2'b01; alu_result = 32'h100; rd = 5'd6;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 40; k++) begin
            #1;
            if (dmem.req === 1'b1) rc++;
            if (memwb_valid === 1'b1) begin pulses++; pulse_wb = memwb_wb; end
            @(negedge clk);
        end
        err_exp = 1;
        checks++;
        if (rc != 16 || pulses != 1 || pulse_wb !== 2'b00 || err !== 1'b1)
            $display("FAIL timeout: got req=%0d pulses=%0d wb=%b err=%b required 16 1 00 1",
                     rc, pulses, pulse_wb, err);
        else passes++;
        run_access(3'b001, 2'b01, 32'h104, 32'h0, 5'd6, 16, 32'h600DF00D, sc, rc, bo, so);
        checks++;
        if (rc != 16 || {memwb_valid, memwb_wb, memwb_rdata} !== {1'b1, 2'b01, 32'h600DF00D})
            $display("FAIL timeout_edge_ready: got req=%0d v=%b wb=%b rdata=%h",
                     rc, memwb_valid, memwb_wb, memwb_rdata);
        else passes++;
    endtask
`endif

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_rtype();
        test_load();
        test_store();
        test_branch();
        test_misaligned();
        test_random();
        test_reset_mid_access();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
